// File: rtl/pipe_pkg.sv
// Shared pipeline types for the EX-stage forwarding controller.
// Register index width, select codes and tracker entry layout.
package pipe_pkg;

  localparam int XLEN_REG = 5;

  typedef logic [XLEN_REG-1:0] reg_t;
  typedef logic [1:0]          fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  typedef struct packed {
    reg_t rd;
    logic wr;
    logic ld;
  } trk_t;

  localparam trk_t TRK_BUBBLE = '{rd: '0, wr: 1'b0, ld: 1'b0};

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage decode bundle and forwarding/stall results.
// master drives decode fields, slave is the controller.
interface fwd_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             id_valid;
  reg_t             id_rs1;
  reg_t             id_rs2;
  reg_t             id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             hold;
  logic             stall;
  fwd_sel_t         fwd_a_sel;
  fwd_sel_t         fwd_b_sel;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd,
    output id_reg_write, id_mem_read,
    output flush, hold,
    input  stall, fwd_a_sel, fwd_b_sel,
    input  stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd,
    input  id_reg_write, id_mem_read,
    input  flush, hold,
    output stall, fwd_a_sel, fwd_b_sel,
    output stall_count
  );

endinterface

// File: rtl/fwd_match.sv
// Per-operand forwarding priority comparator.
// Newest producer (EX) beats older one (MEM); x0 never forwards.
module fwd_match
  import pipe_pkg::*;
(
  input  reg_t     rs_i,
  input  reg_t     ex_rd_i,
  input  logic     ex_wr_i,
  input  reg_t     mem_rd_i,
  input  logic     mem_wr_i,
  output fwd_sel_t sel_o
);

  logic hit_ex;
  logic hit_mem;
  logic nz;

  assign nz      = |rs_i;
  assign hit_ex  = nz & ex_wr_i & (ex_rd_i == rs_i);
  assign hit_mem = nz & mem_wr_i & (mem_rd_i == rs_i);

  // Priority select: EX hit masks any MEM hit
  always_comb begin
    sel_o = FWD_RF;
    unique case (1'b1)
      hit_ex:             sel_o = FWD_EXMEM;
      (hit_mem & ~hit_ex): sel_o = FWD_MEMWB;
      default:            sel_o = FWD_RF;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall controller beside ID/EX.
// Tracks EX/MEM destinations and registers mux selects for EX.
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  trk_t             ex_q, ex_d;
  reg_t             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  fwd_sel_t         sel_a_q, sel_a_d;
  fwd_sel_t         sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fwd_sel_t nxt_a;
  fwd_sel_t nxt_b;
  logic     ld_hit;
  logic     stall;
  logic     take;

  fwd_match u_match_a (
    .rs_i     (bus.id_rs1),
    .ex_rd_i  (ex_q.rd),
    .ex_wr_i  (ex_q.wr),
    .mem_rd_i (mem_rd_q),
    .mem_wr_i (mem_wr_q),
    .sel_o    (nxt_a)
  );

  fwd_match u_match_b (
    .rs_i     (bus.id_rs2),
    .ex_rd_i  (ex_q.rd),
    .ex_wr_i  (ex_q.wr),
    .mem_rd_i (mem_rd_q),
    .mem_wr_i (mem_wr_q),
    .sel_o    (nxt_b)
  );

  // Load in EX feeding either ID source; flush suppresses it
  always_comb begin
    ld_hit = ex_q.ld & ex_q.wr & (|ex_q.rd) &
             ((ex_q.rd == bus.id_rs1) |
              (ex_q.rd == bus.id_rs2));
    stall  = bus.id_valid & ~bus.flush & ld_hit;
    take   = bus.id_valid & ~stall & ~bus.flush;
  end

  // Next tracker, select and counter values
  always_comb begin
    ex_d     = TRK_BUBBLE;
    mem_rd_d = ex_q.rd;
    mem_wr_d = ex_q.wr;
    sel_a_d  = FWD_RF;
    sel_b_d  = FWD_RF;
    cnt_d    = cnt_q;
    if (take) begin
      ex_d.rd = bus.id_rd;
      ex_d.wr = bus.id_reg_write;
      ex_d.ld = bus.id_mem_read;
      sel_a_d = nxt_a;
      sel_b_d = nxt_b;
    end
    if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; hold freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= TRK_BUBBLE;
      mem_rd_q <= '0;
      mem_wr_q <= 1'b0;
      sel_a_q  <= FWD_RF;
      sel_b_q  <= FWD_RF;
      cnt_q    <= '0;
    end else if (!bus.hold) begin
      ex_q     <= ex_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_a_sel   = sel_a_q;
  assign bus.fwd_b_sel   = sel_b_q;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized scoreboard bench for fwd_hazard_ctrl.
// Model keeps a history of the last two issued slots.
module tb_fwd_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fwd_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  fwd_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } ins_t;

  typedef struct {
    bit stall;
    int a;
    int b;
    int cnt;
  } exp_t;

  ins_t hist[$];
  exp_t q[$];
  int   ma;
  int   mb;
  int   mcnt;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void mreset();
    ins_t b;
    b = '{0, 0, 0, 0};
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    ma = 0;
    mb = 0;
    mcnt = 0;
  endfunction

  function automatic int msel(int rs);
    if (rs == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (hist[k].wr && hist[k].rd == rs) return k + 1;
    return 0;
  endfunction

  function automatic bit mstall();
    ins_t n;
    n = hist[0];
    return bus.id_valid && !bus.flush && n.ld && n.wr &&
           n.rd != 0 &&
           (n.rd == int'(bus.id_rs1) ||
            n.rd == int'(bus.id_rs2));
  endfunction

  task automatic step(bit v, int r1, int r2, int rd,
                      bit wr, bit ld, bit fl, bit hd);
    exp_t e;
    ins_t n;
    bit   st;
    bit   acc;
    @(posedge clk);
    #2;
    bus.id_valid     = v;
    bus.id_rs1       = 5'(r1);
    bus.id_rs2       = 5'(r2);
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = wr;
    bus.id_mem_read  = ld;
    bus.flush        = fl;
    bus.hold         = hd;
    #1;
    st = mstall();
    e  = '{st, ma, mb, mcnt};
    q.push_back(e);
    if (!hd) begin
      acc = v && !st && !fl;
      ma  = acc ? msel(r1) : 0;
      mb  = acc ? msel(r2) : 0;
      if (st && mcnt < CMAX) mcnt++;
      n = acc ? '{1, rd, wr, ld} : '{0, 0, 0, 0};
      hist.push_front(n);
      void'(hist.pop_back());
    end
  endtask

  task automatic rst_pulse();
    exp_t e;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_a", int'(bus.fwd_a_sel), 0);
    chk("rst_b", int'(bus.fwd_b_sel), 0);
    chk("rst_cnt", int'(bus.stall_count), 0);
    mreset();
    e = '{0, 0, 0, 0};
    q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", int'(bus.stall), int'(e.stall));
      chk("sel_a", int'(bus.fwd_a_sel), e.a);
      chk("sel_b", int'(bus.fwd_b_sel), e.b);
      chk("count", int'(bus.stall_count), e.cnt);
    end
  end

  initial begin
    int r1, r2, rd;
    bit v, wr, ld, fl, hd, st;
    bus.id_valid     = 1'b0;
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.id_rd        = '0;
    bus.id_reg_write = 1'b0;
    bus.id_mem_read  = 1'b0;
    bus.flush        = 1'b0;
    bus.hold         = 1'b0;
    mreset();
    #3;
    chk("init_stall", int'(bus.stall), 0);
    chk("init_a", int'(bus.fwd_a_sel), 0);
    chk("init_b", int'(bus.fwd_b_sel), 0);
    chk("init_cnt", int'(bus.stall_count), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // ALU chain
    step(1, 1, 2, 5, 1, 0, 0, 0);
    step(1, 5, 7, 6, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // distance 2, then newest wins
    step(1, 1, 2, 5, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 8, 1, 0, 0, 0);
    step(1, 1, 2, 5, 1, 0, 0, 0);
    step(1, 3, 4, 5, 1, 0, 0, 0);
    step(1, 5, 5, 9, 1, 0, 0, 0);
    // load-use
    step(1, 1, 2, 9, 1, 1, 0, 0);
    step(1, 9, 9, 3, 1, 0, 0, 0);
    step(1, 9, 9, 3, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // x0
    step(1, 1, 2, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 2, 0, 1, 1, 0, 0);
    step(1, 0, 0, 2, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // flush over load-use
    step(1, 1, 2, 9, 1, 1, 0, 0);
    step(1, 9, 1, 3, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // hold across a stall
    step(1, 1, 2, 9, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 9, 2, 3, 1, 0, 0, 1);
    step(1, 9, 2, 3, 1, 0, 0, 0);
    step(1, 9, 2, 3, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // reset while stalled
    step(1, 1, 2, 9, 1, 1, 0, 0);
    step(1, 2, 9, 3, 1, 0, 0, 0);
    rst_pulse();
    step(1, 2, 9, 3, 1, 0, 0, 0);
    // saturate the counter
    for (int i = 0; i < CMAX + 3; i++) begin
      step(1, 1, 2, 4, 1, 1, 0, 0);
      step(1, 4, 4, 6, 1, 0, 0, 0);
      step(1, 4, 4, 6, 1, 0, 0, 0);
    end
    rst_pulse();

    // random traffic over a small register set
    r1 = 0; r2 = 0; rd = 0;
    v = 0; wr = 0; ld = 0;
    for (int i = 0; i < 3000; i++) begin
      st = mstall();
      if (!(st && $urandom_range(0, 9) < 7)) begin
        v  = ($urandom_range(0, 9) < 8);
        r1 = $urandom_range(0, 7);
        r2 = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        wr = ($urandom_range(0, 9) < 7);
        ld = ($urandom_range(0, 9) < 4);
      end
      fl = ($urandom_range(0, 9) == 0);
      hd = ($urandom_range(0, 9) == 0);
      step(v, r1, r2, rd, wr, ld, fl, hd);
      if (i % 1000 == 999) rst_pulse();
    end

    repeat (3) @(posedge clk);
    #6;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
